// File: rtl/stream_width_converter.sv
// Packs narrow words into wide ones or splits wide words into slices, little-endian; output registered (latency 1).
// Backpressure: upsize stalls input only on the completing word; downsize refills on the last slice.
module stream_width_converter #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in0_V_V_TVALID && in0_V_V_TREADY;
  assign out_fire = out_V_V_TVALID && out_V_V_TREADY;

  if (OUT_WIDTH > IN_WIDTH) begin : g_up
    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int CW    = $clog2(RATIO);
    localparam int PW    = OUT_WIDTH - IN_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0] count;
    logic [PW-1:0] partial;
    logic          last_word;

    assign last_word      = (count == LAST);
    assign in0_V_V_TREADY = ap_rst_n && !(last_word && out_V_V_TVALID && !out_V_V_TREADY);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        count          <= '0;
        partial        <= '0;
        out_V_V_TDATA  <= '0;
        out_V_V_TVALID <= 1'b0;
      end else begin
        if (out_fire) out_V_V_TVALID <= 1'b0;
        if (in_fire) begin
          if (last_word) begin
            out_V_V_TDATA  <= {in0_V_V_TDATA, partial};
            out_V_V_TVALID <= 1'b1;
            count          <= '0;
            partial        <= '0;
          end else begin
            // Shift toward the LSB so the earliest word ends up in the lowest slice.
            partial <= (partial >> IN_WIDTH) | (PW'(in0_V_V_TDATA) << (PW - IN_WIDTH));
            count   <= count + CW'(1);
          end
        end
      end
    end
  end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = $clog2(RATIO);
    localparam int HW    = IN_WIDTH - OUT_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0] idx;
    logic [HW-1:0] hold;
    logic          last_slice;

    assign last_slice     = (idx == LAST);
    assign in0_V_V_TREADY = ap_rst_n && (!out_V_V_TVALID || (last_slice && out_V_V_TREADY));

    // hold keeps the slices not yet moved into the output register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        idx            <= '0;
        hold           <= '0;
        out_V_V_TDATA  <= '0;
        out_V_V_TVALID <= 1'b0;
      end else if (in_fire) begin
        out_V_V_TDATA  <= in0_V_V_TDATA[OUT_WIDTH-1:0];
        hold           <= in0_V_V_TDATA[IN_WIDTH-1:OUT_WIDTH];
        idx            <= '0;
        out_V_V_TVALID <= 1'b1;
      end else if (out_fire) begin
        if (last_slice) begin
          out_V_V_TVALID <= 1'b0;
          idx            <= '0;
        end else begin
          out_V_V_TDATA <= hold[OUT_WIDTH-1:0];
          hold          <= hold >> OUT_WIDTH;
          idx           <= idx + CW'(1);
        end
      end
    end
  end else begin : g_eq
    assign in0_V_V_TREADY = ap_rst_n && (!out_V_V_TVALID || out_V_V_TREADY);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        out_V_V_TDATA  <= '0;
        out_V_V_TVALID <= 1'b0;
      end else if (in_fire) begin
        out_V_V_TDATA  <= in0_V_V_TDATA;
        out_V_V_TVALID <= 1'b1;
      end else if (out_fire) begin
        out_V_V_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_width_converter.sv
// Bench for 16->32, 32->16 and 16->16 converters: directed handshake/latency cases plus random
// valid/ready traffic scored against a word-list reference model.
module tb_stream_width_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   abort = 1'b0;
  bit   u_done = 1'b0, d_done = 1'b0, e_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] u_in_dat;  logic u_in_vld, u_in_rdy;
  logic [31:0] u_out_dat; logic u_out_vld, u_out_rdy;
  logic [31:0] d_in_dat;  logic d_in_vld, d_in_rdy;
  logic [15:0] d_out_dat; logic d_out_vld, d_out_rdy;
  logic [15:0] e_in_dat;  logic e_in_vld, e_in_rdy;
  logic [15:0] e_out_dat; logic e_out_vld, e_out_rdy;

  stream_width_converter #(.IN_WIDTH(16), .OUT_WIDTH(32)) u_up (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(u_in_dat), .in0_V_V_TVALID(u_in_vld), .in0_V_V_TREADY(u_in_rdy),
    .out_V_V_TDATA(u_out_dat), .out_V_V_TVALID(u_out_vld), .out_V_V_TREADY(u_out_rdy)
  );

  stream_width_converter #(.IN_WIDTH(32), .OUT_WIDTH(16)) u_down (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(d_in_dat), .in0_V_V_TVALID(d_in_vld), .in0_V_V_TREADY(d_in_rdy),
    .out_V_V_TDATA(d_out_dat), .out_V_V_TVALID(d_out_vld), .out_V_V_TREADY(d_out_rdy)
  );

  stream_width_converter #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_eq (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(e_in_dat), .in0_V_V_TVALID(e_in_vld), .in0_V_V_TREADY(e_in_rdy),
    .out_V_V_TDATA(e_out_dat), .out_V_V_TVALID(e_out_vld), .out_V_V_TREADY(e_out_rdy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic report_extra(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output transfer with no expected word pending", name);
  endtask

  // Reference model: collect accepted words, emit expected outputs by plain arithmetic.
  logic [15:0] u_acc[$];
  logic [31:0] u_exp[$];
  logic [15:0] d_exp[$];
  logic [15:0] e_exp[$];
  int          d_ocyc[$];
  logic [31:0] u_word;

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_in_vld && u_in_rdy) begin
        u_acc.push_back(u_in_dat);
        if (u_acc.size() == 2) begin
          u_word = '0;
          foreach (u_acc[i]) u_word = u_word | (32'(u_acc[i]) << (16 * i));
          u_exp.push_back(u_word);
          u_acc.delete();
        end
      end
      if (d_in_vld && d_in_rdy)
        for (int i = 0; i < 2; i++) d_exp.push_back(16'(d_in_dat >> (16 * i)));
      if (e_in_vld && e_in_rdy) e_exp.push_back(e_in_dat);
    end
  end

  // Output monitors: scoreboard pop plus hold-while-stalled check.
  logic u_stall = 1'b0, d_stall = 1'b0, e_stall = 1'b0;
  logic [31:0] u_held;
  logic [15:0] d_held, e_held;
  int u_ocount = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      u_stall <= 1'b0;
      d_stall <= 1'b0;
      e_stall <= 1'b0;
    end else begin
      if (u_stall) begin
        check("up_hold_vld", u_out_vld, 1);
        check("up_hold_dat", u_out_dat, u_held);
      end
      if (d_stall) begin
        check("dn_hold_vld", d_out_vld, 1);
        check("dn_hold_dat", d_out_dat, d_held);
      end
      if (e_stall) begin
        check("eq_hold_vld", e_out_vld, 1);
        check("eq_hold_dat", e_out_dat, e_held);
      end
      if (u_out_vld && u_out_rdy) begin
        u_ocount <= u_ocount + 1;
        if (u_exp.size() == 0) report_extra("up_extra");
        else check("up_data", u_out_dat, u_exp.pop_front());
      end
      if (d_out_vld && d_out_rdy) begin
        d_ocyc.push_back(cyc);
        if (d_exp.size() == 0) report_extra("dn_extra");
        else check("dn_data", d_out_dat, d_exp.pop_front());
      end
      if (e_out_vld && e_out_rdy) begin
        if (e_exp.size() == 0) report_extra("eq_extra");
        else check("eq_data", e_out_dat, e_exp.pop_front());
      end
      u_stall <= u_out_vld && !u_out_rdy;  u_held <= u_out_dat;
      d_stall <= d_out_vld && !d_out_rdy;  d_held <= d_out_dat;
      e_stall <= e_out_vld && !e_out_rdy;  e_held <= e_out_dat;
    end
  end

  task automatic timeout(input string name, input int waited);
    n_tests++;
    n_fail++;
    abort = 1'b1;
    $display("FAIL %s: input not accepted after %0d cycles, required fewer than 500", name, waited);
  endtask

  task automatic send_u(input logic [15:0] w, output int waited);
    u_in_dat = w; u_in_vld = 1'b1; waited = 0;
    while (!abort) begin
      @(negedge clk);
      if (u_in_rdy) break;
      waited++;
      if (waited >= 500) timeout("up_send", waited);
    end
    @(posedge clk); #1;
    u_in_vld = 1'b0;
  endtask

  task automatic send_d(input logic [31:0] w, output int waited);
    d_in_dat = w; d_in_vld = 1'b1; waited = 0;
    while (!abort) begin
      @(negedge clk);
      if (d_in_rdy) break;
      waited++;
      if (waited >= 500) timeout("dn_send", waited);
    end
    @(posedge clk); #1;
    d_in_vld = 1'b0;
  endtask

  task automatic send_e(input logic [15:0] w, output int waited);
    e_in_dat = w; e_in_vld = 1'b1; waited = 0;
    while (!abort) begin
      @(negedge clk);
      if (e_in_rdy) break;
      waited++;
      if (waited >= 500) timeout("eq_send", waited);
    end
    @(posedge clk); #1;
    e_in_vld = 1'b0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    u_acc.delete(); u_exp.delete(); d_exp.delete(); e_exp.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c0;
    assert_reset();
    u_in_vld = 0; d_in_vld = 0; e_in_vld = 0;
    u_in_dat = '0; d_in_dat = '0; e_in_dat = '0;
    u_out_rdy = 0; d_out_rdy = 0; e_out_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_up_vld", u_out_vld, 0); check("rst_up_dat", u_out_dat, 0); check("rst_up_rdy", u_in_rdy, 0);
    check("rst_dn_vld", d_out_vld, 0); check("rst_dn_dat", d_out_dat, 0); check("rst_dn_rdy", d_in_rdy, 0);
    check("rst_eq_vld", e_out_vld, 0); check("rst_eq_dat", e_out_dat, 0); check("rst_eq_rdy", e_in_rdy, 0);
    rst_n = 1'b1;

    // Upsize, sink always ready
    u_out_rdy = 1;
    send_u(16'h1111, w); check("up_first_accept_wait", w, 0); check("up_no_early_out", u_out_vld, 0);
    send_u(16'h2222, w); check("up_lat_vld", u_out_vld, 1); check("up_lat_dat", u_out_dat, 32'h22221111);
    send_u(16'h3333, w); send_u(16'h4444, w); check("up_b2b_wait", w, 0);
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_u(16'($urandom), w);
    check("up_tput_cycles", cyc - c0, 8);
    repeat (3) @(posedge clk);
    #1; check("up_drain", u_exp.size(), 0);

    // Upsize, sink stalled while first output held
    u_out_rdy = 0;
    send_u(16'h1111, w); send_u(16'h2222, w);
    send_u(16'h3333, w); check("up_stall_accept_wait", w, 0);
    u_in_dat = 16'h4444; u_in_vld = 1;
    @(negedge clk); check("up_stall_rdy_low", u_in_rdy, 0);
    @(negedge clk); check("up_stall_rdy_low2", u_in_rdy, 0);
    @(posedge clk); #1; u_out_rdy = 1;
    @(negedge clk); check("up_refill_rdy", u_in_rdy, 1); check("up_refill_out_vld", u_out_vld, 1);
    @(posedge clk); #1; u_in_vld = 0;
    check("up_refill_vld", u_out_vld, 1); check("up_refill_dat", u_out_dat, 32'h44443333);
    repeat (3) @(posedge clk);
    #1; check("up_stall_drain", u_exp.size(), 0);

    // Downsize, back-to-back words, sink always ready
    d_out_rdy = 1; d_ocyc.delete();
    send_d(32'hAAAABBBB, w); check("dn_first_wait", w, 0);
    check("dn_lat_vld", d_out_vld, 1); check("dn_lat_dat", d_out_dat, 16'hBBBB);
    send_d(32'hCCCCDDDD, w); check("dn_second_wait", w, 1);
    repeat (4) @(posedge clk);
    #1; check("dn_slices", d_ocyc.size(), 4);
    if (d_ocyc.size() == 4) check("dn_no_bubble", d_ocyc[3] - d_ocyc[0], 3);
    check("dn_drain", d_exp.size(), 0);

    // Equal width pass-through
    e_out_rdy = 1;
    send_e(16'h1234, w); check("eq_lat_vld", e_out_vld, 1); check("eq_lat_dat", e_out_dat, 16'h1234);
    c0 = cyc;
    for (int i = 0; i < 20; i++) send_e(16'($urandom), w);
    check("eq_tput_cycles", cyc - c0, 20);
    repeat (3) @(posedge clk);
    #1; check("eq_drain", e_exp.size(), 0);

    // Reset mid-operation: held output plus one partial word are discarded
    u_out_rdy = 0;
    send_u(16'h1111, w); send_u(16'h2222, w); send_u(16'h3333, w);
    #2; assert_reset();
    #1;
    check("rst_mid_vld", u_out_vld, 0); check("rst_mid_dat", u_out_dat, 0); check("rst_mid_rdy", u_in_rdy, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; u_out_rdy = 1;
    c0 = u_ocount;
    send_u(16'h5555, w); check("rst_first_accept_wait", w, 0);
    send_u(16'h6666, w);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_count", u_ocount - c0, 1); check("rst_drain", u_exp.size(), 0);

    // Random valid/ready traffic in all three modes
    fork
      begin
        int wu;
        for (int i = 0; i < 1000 && !abort; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_u(16'($urandom), wu);
        end
        u_done = 1;
      end
      begin
        int wd;
        for (int i = 0; i < 1000 && !abort; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_d($urandom, wd);
        end
        d_done = 1;
      end
      begin
        int we;
        for (int i = 0; i < 300 && !abort; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_e(16'($urandom), we);
        end
        e_done = 1;
      end
      begin
        int c;
        c = 0;
        while (!(u_done && d_done && e_done && u_exp.size() == 0 && d_exp.size() == 0 &&
                 e_exp.size() == 0) && !abort && c < 40000) begin
          @(posedge clk); #1;
          u_out_rdy = ($urandom_range(0, 3) != 0);
          d_out_rdy = ($urandom_range(0, 3) != 0);
          e_out_rdy = ($urandom_range(0, 3) != 0);
          c++;
        end
        check("rand_within_bound", c < 40000, 1);
      end
    join
    check("rand_up_drain", u_exp.size(), 0);
    check("rand_up_partial", u_acc.size(), 0);
    check("rand_dn_drain", d_exp.size(), 0);
    check("rand_eq_drain", e_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_width_converter.md
STREAM_WIDTH_CONVERTER -- requirements
Module: stream_width_converter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, input stream data width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, output stream data width in bits.
REQ-003 SHALL require that one of IN_WIDTH and OUT_WIDTH is an integer multiple of the other; RATIO = larger/smaller.
REQ-004 SHALL have port ap_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port ap_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in0_V_V_TDATA  input  IN_WIDTH  input stream data.
REQ-007 SHALL have port in0_V_V_TVALID  input  1  input word valid.
REQ-008 SHALL have port in0_V_V_TREADY  output  1  block accepts input word.
REQ-009 SHALL have port out_V_V_TDATA  output  OUT_WIDTH  output stream data.
REQ-010 SHALL have port out_V_V_TVALID  output  1  output word valid.
REQ-011 SHALL have port out_V_V_TREADY  input  1  consumer accepts output word.

Function
REQ-012 SHALL transfer a word on a port only in a cycle where TVALID and TREADY are both 1 at the rising edge.
REQ-013 SHALL hold out_V_V_TDATA stable and out_V_V_TVALID at 1 from assertion until the transfer occurs.
REQ-014 SHALL pack and unpack little-endian: the earliest input word or output slice occupies bits [k-1:0].
REQ-015 SHALL register out_V_V_TDATA and out_V_V_TVALID; in0_V_V_TREADY may combine registered state with out_V_V_TREADY.
REQ-016 SHALL not drop, duplicate or reorder data under any pattern of TVALID or TREADY.
REQ-017 SHALL, in upsize mode (OUT_WIDTH > IN_WIDTH), collect words into a partial buffer with count 0..RATIO-1.
REQ-018 SHALL, in upsize mode, move the partial buffer plus the accepted word into the output register on acceptance of the word at count RATIO-1, clear count, and assert out_V_V_TVALID the next cycle, giving a latency of 1 cycle after the last input word.
REQ-019 SHALL, in upsize mode, accept words at counts 0..RATIO-2 even while the output register is full and stalled.
REQ-020 SHALL, in upsize mode, deassert in0_V_V_TREADY only when count == RATIO-1, out_V_V_TVALID = 1 and out_V_V_TREADY = 0.
REQ-021 SHALL, in upsize mode, sustain one input word per cycle when the consumer is always ready.
REQ-022 SHALL, in downsize mode (IN_WIDTH > OUT_WIDTH), load an accepted input word into a hold register and emit RATIO slices in order, slice index 0..RATIO-1.
REQ-023 SHALL, in downsize mode, assert in0_V_V_TREADY when the hold register is empty, or when slice RATIO-1 is being transferred that cycle, so back-to-back words give one output slice per cycle with no bubble.
REQ-024 SHALL, in downsize mode, give a latency of 1 cycle from input acceptance to slice 0 being valid.
REQ-025 SHALL, when IN_WIDTH == OUT_WIDTH, act as a single register stage with latency 1 and in0_V_V_TREADY = !out_V_V_TVALID || out_V_V_TREADY.
REQ-026 SHALL handle a simultaneous output transfer and refill in the same cycle, keeping out_V_V_TVALID at 1 with the new data.

Reset
REQ-027 SHALL, while ap_rst_n = 0, asynchronously clear out_V_V_TVALID to 0, out_V_V_TDATA to 0, all counters and slice indices to 0, and the partial and hold buffers to 0.
REQ-028 SHALL force in0_V_V_TREADY to 0 while ap_rst_n = 0.
REQ-029 SHALL discard any partially collected or partially emitted word when reset is asserted mid-operation.
REQ-030 SHALL, after reset release, first accept input on the first rising edge at which in0_V_V_TVALID = 1.

Verification
REQ-031 SHALL cover upsize 16->32, inputs 0x1111, 0x2222, 0x3333, 0x4444, sink always ready -> outputs 0x22221111 then 0x44443333, first output valid 1 cycle after 0x2222 is accepted.
REQ-032 SHALL cover upsize 16->32 with sink stalled while 0x22221111 is held -> 0x3333 accepted, in0_V_V_TREADY = 0 at count 1, and 0x4444 accepted in the cycle the sink takes 0x22221111.
REQ-033 SHALL cover downsize 32->16, inputs 0xAAAABBBB, 0xCCCCDDDD back-to-back, sink always ready -> outputs 0xBBBB, 0xAAAA, 0xDDDD, 0xCCCC on 4 consecutive cycles.
REQ-034 SHALL cover random TVALID and TREADY toggling over 1000 words in both modes -> scoreboard matches, TDATA stable while stalled.
REQ-035 SHALL cover reset asserted after 1 of 2 upsize words -> out_V_V_TVALID = 0 immediately; after release, 0x5555, 0x6666 produce exactly 0x66665555.
REQ-036 SHALL cover IN_WIDTH = OUT_WIDTH = 16, input 0x1234 -> out 0x1234 one cycle later, full throughput with sink always ready.
